// File: rtl/ps2_cursor_ctrl.sv
// ps2_cursor_ctrl: PS/2 keyboard receiver and ball cursor/colour controller.
// The PS/2 clock is glitch filtered. Each frame is checked for its start bit,
// odd parity and stop bit. A watchdog aborts stalled frames. E0 and F0 prefixes
// are decoded, and one pulse is emitted per key event. Arrow, colour and Escape
// keys then move and recolour the ball, with moves clamped against the radius.
// Optional build macro PS2_TYPEMATIC_EN: when defined, arrow keys act on make
// events (typematic repeats move the ball), and arrow break events are ignored.
module ps2_cursor_ctrl #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int COORD_W     = 11,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int STEP        = 5,
  parameter int RAD_W       = 3,
  parameter int RAD_SCALE   = 5
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  input  logic [RAD_W-1:0]   radius,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_break,
  output logic               frame_err,
  output logic [1:0]         color,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SW   = COORD_W + 2;
  localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
  localparam logic signed [SW-1:0] XM1_S  = SW'(X_MAX - 1);
  localparam logic signed [SW-1:0] YM1_S  = SW'(Y_MAX - 1);
  localparam logic signed [SW-1:0] ZERO_S = '0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Two-flop synchronisers for both raw PS/2 lines (bus idles high)
  logic [1:0] clk_sync_q, dat_sync_q;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DATA};
    end
  end

  // Filtered clock changes only after FILT_LEN consecutive differing samples
  logic            clk_filt_q, clk_filt_d;
  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
  logic            fall_q, fall_d;
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == FC_W'(FILT_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall_d = clk_filt_q & ~clk_filt_d;
  end

  // Filter state and the one-cycle fall strobe
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
    end
  end

  // Receiver FSM with watchdog; a good byte strobes out the cycle after STOP
  state_t          state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q, byte_q;
  logic            par_q, byte_vld_q, frame_err_q;
  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_expire;
  assign wd_expire = (state_q != IDLE) && !fall_q && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == IDLE || fall_q) wd_cnt_q <= '0;
      else                           wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_expire) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end else if (fall_q) begin
        case (state_q)
          IDLE: begin
            bit_cnt_q <= '0;
            if (!dat_sync_q[1]) state_q <= DATA;
          end
          DATA: begin
            shift_q   <= {dat_sync_q[1], shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_sync_q[1];
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (dat_sync_q[1] && ^{shift_q, par_q}) begin
              byte_vld_q <= 1'b1;
              byte_q     <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  function automatic logic in_bounds(input logic signed [SW-1:0] c, r, mx);
    return (c - r >= ZERO_S) && (c + r <= mx);
  endfunction

  // Prefix decode, event output and ball/colour actions
  logic                ext_q, ext_d, brk_q, brk_d;
  logic                key_valid_q, key_valid_d, key_ext_q, key_ext_d, key_break_q, key_break_d;
  logic [7:0]          key_code_q, key_code_d;
  logic [1:0]          color_q, color_d, pend_q, pend_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic signed [SW-1:0] rad_px, x_s, y_s, x_dec, x_inc, y_dec, y_inc;
  logic                arrow_act, cmd_act;
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    color_d     = color_q;
    pend_d      = pend_q;
    x_d         = x_q;
    y_d         = y_q;
    rad_px = $signed(SW'(radius) * SW'(RAD_SCALE));
    x_s    = $signed({2'b00, x_q});
    y_s    = $signed({2'b00, y_q});
    x_dec  = x_s - STEP_S;
    x_inc  = x_s + STEP_S;
    y_dec  = y_s - STEP_S;
    y_inc  = y_s + STEP_S;

    if (wd_expire) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == 8'hE0)      ext_d = 1'b1;
      else if (byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        key_valid_d = 1'b1;
        key_code_d  = byte_q;
        key_ext_d   = ext_q;
        key_break_d = brk_q;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end
    end

`ifdef PS2_TYPEMATIC_EN
    arrow_act = key_valid_q & ~key_break_q;
`else
    arrow_act = key_valid_q & key_break_q;
`endif
    cmd_act = key_valid_q & key_break_q;

    if (arrow_act) begin
      case (key_code_q)
        8'h75: if (in_bounds(y_dec, rad_px, YM1_S)) y_d = y_dec[COORD_W-1:0];
        8'h72: if (in_bounds(y_inc, rad_px, YM1_S)) y_d = y_inc[COORD_W-1:0];
        8'h6B: if (in_bounds(x_dec, rad_px, XM1_S)) x_d = x_dec[COORD_W-1:0];
        8'h74: if (in_bounds(x_inc, rad_px, XM1_S)) x_d = x_inc[COORD_W-1:0];
        default: ;
      endcase
    end
    if (cmd_act) begin
      case (key_code_q)
        8'h16: pend_d = 2'd1;
        8'h1E: pend_d = 2'd2;
        8'h26: pend_d = 2'd3;
        8'h5A: color_d = pend_q;
        8'h76: begin
          x_d     = COORD_W'(X_INIT);
          y_d     = COORD_W'(Y_INIT);
          color_d = 2'd1;
          pend_d  = 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Decode and action state
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      color_q     <= 2'd1;
      pend_q      <= 2'd1;
      x_q         <= COORD_W'(X_INIT);
      y_q         <= COORD_W'(Y_INIT);
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      color_q     <= color_d;
      pend_q      <= pend_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign frame_err = frame_err_q;
  assign color     = color_q;
  assign ball_x    = x_q;
  assign ball_y    = y_q;

endmodule
